// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: a saturating pending-write count per GPR, tracking of the
// load in EX, and a combinational stall that depends on whether the pipeline has bypassing.
module hazard_scoreboard #(
    parameter int FORWARDING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_regwrite,
    input  logic        issue_memread,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush_valid,
    input  logic [4:0]  flush_rd,
    output logic        stall,
    output logic [31:0] pending_mask,
    output logic        err
);

    logic [1:0] count      [32];
    logic [1:0] count_next [32];
    logic       err_set;
    logic       accept;
    logic       ex_load_valid;
    logic [4:0] ex_load_rd;

    // Returns {error, next_count}. One increment and up to two decrements can land together;
    // the net result is clamped to 0..3, and clamping counts as a protocol error.
    function automatic logic [2:0] next_count(input logic [1:0] cur, input logic inc,
                                              input logic dec_a, input logic dec_b);
        logic [2:0] up;
        logic [2:0] down;
        up   = {1'b0, cur} + {2'b00, inc};
        down = {2'b00, dec_a} + {2'b00, dec_b};
        if (up < down)
            return {1'b1, 2'd0};
        else if ((up - down) > 3'd3)
            return {1'b1, 2'd3};
        else
            return {1'b0, 2'(up - down)};
    endfunction

    // The register file writes before it reads, so a WB that retires the only pending
    // writer of a source is already visible in ID.
    function automatic logic src_hazard(input logic [4:0] rs, input logic used,
                                        input logic [1:0] cnt, input logic wbv,
                                        input logic [4:0] wbr);
        return used && (rs != 5'd0) && (cnt != 2'd0)
               && !(wbv && (wbr == rs) && (cnt == 2'd1));
    endfunction

    assign accept = issue_valid && !stall;

    generate
        if (FORWARDING != 0) begin : g_fwd
            always_comb begin
                stall = ex_load_valid &&
                        ((id_use_rs1 && (id_rs1 == ex_load_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_load_rd)));
            end
        end else begin : g_nofwd
            always_comb begin
                stall = src_hazard(id_rs1, id_use_rs1, count[id_rs1], wb_valid, wb_rd) ||
                        src_hazard(id_rs2, id_use_rs2, count[id_rs2], wb_valid, wb_rd);
            end
        end
    endgenerate

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        err_set       = 1'b0;
        count_next[0] = 2'd0;
        for (int r = 1; r < 32; r++) begin
            logic [2:0] res;
            res = next_count(count[r],
                             accept && issue_regwrite && (issue_rd == 5'(r)),
                             wb_valid && (wb_rd == 5'(r)),
                             flush_valid && (flush_rd == 5'(r)));
            count_next[r] = res[1:0];
            err_set       = err_set | res[2];
        end
    end

    always_comb begin
        pending_mask[0] = 1'b0;
        for (int r = 1; r < 32; r++)
            pending_mask[r] = (count[r] != 2'd0);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every reader sees pre-edge values.
        if (rst) begin
            for (int r = 0; r < 32; r++)
                count[r] <= 2'd0;
            ex_load_valid <= 1'b0;
            ex_load_rd    <= 5'd0;
            err           <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++)
                count[r] <= count_next[r];
            if (err_set)
                err <= 1'b1;
            // A bubble or a squash leaves no load in EX.
            ex_load_valid <= !flush_valid && accept && issue_memread && issue_regwrite
                             && (issue_rd != 5'd0);
            if (accept)
                ex_load_rd <= issue_rd;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives one FORWARDING=0 and one FORWARDING=1 scoreboard with identical stimulus and compares
// both against a per-register integer model, using directed scenarios followed by random traffic.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_regwrite, issue_memread;
    logic [4:0]  issue_rd, id_rs1, id_rs2, wb_rd, flush_rd;
    logic        id_use_rs1, id_use_rs2, wb_valid, flush_valid;
    logic        stall0, stall1, err0, err1;
    logic [31:0] mask0, mask1;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FORWARDING(0)) dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush_valid(flush_valid), .flush_rd(flush_rd),
        .stall(stall0), .pending_mask(mask0), .err(err0)
    );

    hazard_scoreboard #(.FORWARDING(1)) dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush_valid(flush_valid), .flush_rd(flush_rd),
        .stall(stall1), .pending_mask(mask1), .err(err1)
    );

    int checks = 0;
    int errors = 0;

    // Reference state, index 0 = no bypass, index 1 = bypass.
    int cnt [2][32];
    bit ld_v [2];
    int ld_rd [2];
    bit m_err [2];

    // Values sampled in the most recent cycle, for scenario-specific checks.
    logic        s_stall [2];
    logic [31:0] s_mask  [2];
    logic        s_err   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit uses_pending(int f, logic [4:0] rs, logic used);
        if (!used || rs == 0 || cnt[f][rs] == 0) return 0;
        if (wb_valid && wb_rd == rs && cnt[f][rs] == 1) return 0;
        return 1;
    endfunction

    function automatic bit m_stall(int f);
        if (f == 1)
            return ld_v[1] && ((id_use_rs1 && int'(id_rs1) == ld_rd[1]) ||
                               (id_use_rs2 && int'(id_rs2) == ld_rd[1]));
        return uses_pending(0, id_rs1, id_use_rs1) || uses_pending(0, id_rs2, id_use_rs2);
    endfunction

    function automatic logic [31:0] m_mask(int f);
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) m[r] = (cnt[f][r] != 0);
        return m;
    endfunction

    task automatic m_update(input bit st0, input bit st1);
        for (int f = 0; f < 2; f++) begin
            bit acc;
            acc = issue_valid && !(f == 0 ? st0 : st1);
            if (rst) begin
                for (int r = 0; r < 32; r++) cnt[f][r] = 0;
                ld_v[f] = 0; ld_rd[f] = 0; m_err[f] = 0;
            end else begin
                for (int r = 1; r < 32; r++) begin
                    int n;
                    n = cnt[f][r]
                        + int'(acc && issue_regwrite && int'(issue_rd) == r)
                        - int'(wb_valid && int'(wb_rd) == r)
                        - int'(flush_valid && int'(flush_rd) == r);
                    if (n > 3) begin n = 3; m_err[f] = 1; end
                    if (n < 0) begin n = 0; m_err[f] = 1; end
                    cnt[f][r] = n;
                end
                if (flush_valid) ld_v[f] = 0;
                else ld_v[f] = acc && issue_memread && issue_regwrite && issue_rd != 0;
                if (acc) ld_rd[f] = int'(issue_rd);
            end
        end
    endtask

    // Compares outputs in mid-cycle, then advances the model across the next rising edge.
    task automatic cycle(input string tag);
        bit st0, st1;
        @(negedge clk);
        st0 = m_stall(0);
        st1 = m_stall(1);
        s_stall[0] = stall0; s_stall[1] = stall1;
        s_mask[0]  = mask0;  s_mask[1]  = mask1;
        s_err[0]   = err0;   s_err[1]   = err1;
        check({tag, "/stall0"}, {31'd0, stall0}, {31'd0, st0});
        check({tag, "/stall1"}, {31'd0, stall1}, {31'd0, st1});
        check({tag, "/mask0"}, mask0, m_mask(0));
        check({tag, "/mask1"}, mask1, m_mask(1));
        check({tag, "/err0"}, {31'd0, err0}, {31'd0, m_err[0]});
        check({tag, "/err1"}, {31'd0, err1}, {31'd0, m_err[1]});
        @(posedge clk);
        m_update(st0, st1);
        #1;
    endtask

    task automatic idle();
        rst = 0; issue_valid = 0; issue_rd = 0; issue_regwrite = 0; issue_memread = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        wb_valid = 0; wb_rd = 0; flush_valid = 0; flush_rd = 0;
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst = 1;
        cycle(tag);
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic load);
        issue_valid = 1; issue_rd = rd; issue_regwrite = 1; issue_memread = load;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        m_update(0, 0);
        #1;
        idle();

        cycle("reset_state");
        check("reset_mask", s_mask[1], 32'h0);
        check("reset_stall", {31'd0, s_stall[1]}, 32'd0);

        // Load-use: one-cycle stall with bypass, pending until WB.
        issue(5'd5, 1); cycle("ld5_issue");
        issue(5'd6, 0); id_rs1 = 5'd5; id_use_rs1 = 1; cycle("ld5_use_a");
        check("loaduse_stall_first", {31'd0, s_stall[1]}, 32'd1);
        check("loaduse_mask5", {31'd0, s_mask[1][5]}, 32'd1);
        cycle("ld5_use_b");
        check("loaduse_stall_second", {31'd0, s_stall[1]}, 32'd0);
        idle(); wb_valid = 1; wb_rd = 5'd5; cycle("ld5_wb");
        idle(); cycle("ld5_after");
        check("loaduse_mask5_cleared", {31'd0, s_mask[1][5]}, 32'd0);

        // ALU result consumed next cycle: no stall with bypass.
        do_reset("rst_b");
        issue(5'd7, 0); cycle("add7_issue");
        idle(); id_rs2 = 5'd7; id_use_rs2 = 1; cycle("add7_use");
        check("alu_use_nostall", {31'd0, s_stall[1]}, 32'd0);

        // Count saturation and issue+WB netting to zero.
        do_reset("rst_c");
        issue(5'd3, 0); cycle("c3_issue1");
        issue(5'd3, 0); wb_valid = 1; wb_rd = 5'd3; cycle("c3_issue_wb");
        idle(); cycle("c3_net");
        check("net_zero_mask3", {31'd0, s_mask[0][3]}, 32'd1);
        check("net_zero_err", {31'd0, s_err[0]}, 32'd0);
        issue(5'd3, 0); cycle("c3_issue2");
        issue(5'd3, 0); cycle("c3_issue3");
        issue(5'd3, 0); cycle("c3_issue4");
        idle(); cycle("c3_sat");
        check("saturate_err", {31'd0, s_err[0]}, 32'd1);

        // WB on the only pending writer of a source removes the stall without bypass.
        do_reset("rst_d");
        issue(5'd9, 0); cycle("r9_issue");
        idle(); id_rs1 = 5'd9; id_use_rs1 = 1; cycle("r9_nowb");
        check("nofwd_stall_pending", {31'd0, s_stall[0]}, 32'd1);
        wb_valid = 1; wb_rd = 5'd9; cycle("r9_wb");
        check("nofwd_wb_bypass", {31'd0, s_stall[0]}, 32'd0);

        // x0 is never tracked; WB underflow flags an error.
        do_reset("rst_e");
        issue(5'd0, 0); id_rs1 = 5'd0; id_use_rs1 = 1; cycle("x0_issue");
        check("x0_nostall", {31'd0, s_stall[0]}, 32'd0);
        idle(); wb_valid = 1; wb_rd = 5'd12; cycle("wb12_under");
        check("x0_mask", s_mask[0], 32'h0);
        idle(); cycle("wb12_after");
        check("underflow_err", {31'd0, s_err[0]}, 32'd1);
        check("underflow_mask12", {31'd0, s_mask[0][12]}, 32'd0);

        // Flush squashes the EX load; then reset mid-stream.
        do_reset("rst_f");
        issue(5'd4, 1); cycle("ld4_issue");
        idle(); flush_valid = 1; flush_rd = 5'd4; cycle("ld4_flush");
        idle(); id_rs1 = 5'd4; id_use_rs1 = 1; cycle("ld4_after");
        check("flush_stall", {31'd0, s_stall[1]}, 32'd0);
        check("flush_mask4", {31'd0, s_mask[1][4]}, 32'd0);
        idle(); issue(5'd10, 0); wb_valid = 1; wb_rd = 5'd20; cycle("mid_work");
        do_reset("mid_rst");
        cycle("mid_after");
        check("midrst_mask", s_mask[0] | s_mask[1], 32'h0);
        check("midrst_err", {31'd0, s_err[0] | s_err[1]}, 32'd0);

        // Random traffic on a small register window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst            = ($urandom_range(0, 99) == 0);
            issue_valid    = ($urandom_range(0, 9) < 7);
            issue_rd       = 5'($urandom_range(0, 7));
            issue_regwrite = ($urandom_range(0, 9) < 8);
            issue_memread  = ($urandom_range(0, 9) < 3);
            id_rs1         = 5'($urandom_range(0, 7));
            id_rs2         = 5'($urandom_range(0, 7));
            id_use_rs1     = $urandom_range(0, 1) != 0;
            id_use_rs2     = $urandom_range(0, 1) != 0;
            wb_valid       = ($urandom_range(0, 9) < 4);
            wb_rd          = 5'($urandom_range(0, 7));
            for (int k = 0; k < 8 && cnt[1][wb_rd] == 0; k++)
                wb_rd = 5'($urandom_range(1, 7));
            flush_valid    = ($urandom_range(0, 9) == 0);
            flush_rd       = 5'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter FORWARDING, default 1, meaning: 1 = pipeline has EX/MEM and MEM/WB bypass, so stall only on load-use; 0 = no bypass, so stall on any pending write.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port issue_valid, input, 1, meaning the instruction in ID requests to move to EX this cycle.
REQ-005 SHALL have port issue_rd, input, 5, the destination register of the issuing instruction.
REQ-006 SHALL have port issue_regwrite, input, 1, meaning the issuing instruction writes rd.
REQ-007 SHALL have port issue_memread, input, 1, meaning the issuing instruction is a load.
REQ-008 SHALL have ports id_rs1 and id_rs2, input, 5 each, the source registers of the ID instruction.
REQ-009 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each, meaning the ID instruction reads that source.
REQ-010 SHALL have ports wb_valid (input, 1) and wb_rd (input, 5), meaning a register write retires in WB this cycle.
REQ-011 SHALL have ports flush_valid (input, 1) and flush_rd (input, 5), meaning an in-flight writer with rd flush_rd is squashed this cycle.
REQ-012 SHALL have port stall, output, 1, meaning hold PC and IF/ID and insert a bubble into ID/EX.
REQ-013 SHALL have port pending_mask, output, 32, where bit i = 1 iff the count for register i is nonzero.
REQ-014 SHALL have port err, output, 1, a sticky protocol-error flag.

Function
REQ-015 SHALL hold one 2-bit saturating pending count per register 1..31; register x0 SHALL never be counted, and pending_mask[0] SHALL be 0.
REQ-016 SHALL define accept = issue_valid && !stall; issue inputs with accept=0 SHALL have no effect.
REQ-017 SHALL increment count[issue_rd] on accept && issue_regwrite && issue_rd!=0.
REQ-018 SHALL decrement count[wb_rd] on wb_valid && wb_rd!=0, and SHALL decrement count[flush_rd] on flush_valid && flush_rd!=0.
REQ-019 SHALL compute the net change per register from all three events in the same cycle, so that issue and WB on the same register leave the count unchanged.
REQ-020 SHALL, when an increment would exceed 3, keep the count at 3 and set err.
REQ-021 SHALL, when a decrement would go below 0, keep the count at 0 and set err.
REQ-022 SHALL hold err at 1 once set, until rst.
REQ-023 SHALL keep an EX-stage load tracker (ex_load_valid, ex_load_rd), updated every cycle as follows:
- on accept: valid = issue_memread && issue_regwrite && issue_rd!=0, and rd = issue_rd;
- otherwise: valid = 0 (a bubble).
REQ-024 SHALL clear ex_load_valid on flush_valid, with priority over the REQ-023 update in the same cycle.
REQ-025 SHALL, with FORWARDING=1, assert stall = ex_load_valid && ((id_use_rs1 && id_rs1==ex_load_rd) || (id_use_rs2 && id_rs2==ex_load_rd)).
REQ-026 SHALL, with FORWARDING=0, assert stall when a used source rsX!=0 has count[rsX]!=0, except when wb_valid && wb_rd==rsX && count[rsX]==1 (the register file writes before it reads).
REQ-027 SHALL compute stall combinationally from registered state and current inputs, with zero-cycle latency.
REQ-028 SHALL let a load-use stall last exactly 1 cycle with FORWARDING=1, because the bubble clears ex_load_valid.
REQ-029 SHALL update pending_mask one cycle after the event that changes a count.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, set all counts to 0, ex_load_valid=0, ex_load_rd=0 and err=0, overriding all other events in that cycle.
REQ-031 SHALL, after reset, present pending_mask=32'h0 and stall=0 until state changes.
REQ-032 SHALL, on rst asserted mid-operation, discard all in-flight tracking; later wb_valid events for discarded writers SHALL set err.

Verification
REQ-033 SHALL cover: FORWARDING=1; issue load rd=5, next cycle id_rs1=5 with use -> stall=1 for exactly 1 cycle, then 0; pending_mask[5]=1 until wb_rd=5.
REQ-034 SHALL cover: FORWARDING=1; issue add rd=7, next cycle id_rs2=7 -> stall=0.
REQ-035 SHALL cover: FORWARDING=0; issue rd=3 three times with no WB -> count 3, a 4th issue -> err=1; issue rd=3 and wb_rd=3 in the same cycle -> count unchanged.
REQ-036 SHALL cover: FORWARDING=0; count[9]=1, id_rs1=9 with wb_valid, wb_rd=9 in the same cycle -> stall=0; without wb -> stall=1.
REQ-037 SHALL cover: issue rd=0 and id_rs1=0 -> no count change, stall=0; wb_rd=12 with count 0 -> err=1 and count stays 0.
REQ-038 SHALL cover: load rd=4 issued, flush_valid with flush_rd=4 next cycle -> ex_load_valid=0, stall=0, pending_mask[4]=0; rst mid-stream -> pending_mask=0 and err=0.
